// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t    - LSU sequencing states
//   SZ_*           - funct3 access-size encodings
//   size_legal     - 1 when funct3 names a supported access size
//   misaligned     - 1 when the byte offset is not aligned for the size
//   byte_enable    - bus byte-enable mask for a size/offset pair
//   store_lanes    - store data replicated across all byte lanes
package rv32_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic size_legal(logic [2:0] size);
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_legal = 1'b1;
      default:                        size_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(logic [2:0] size, logic [1:0] offset);
    case (size)
      SZ_H, SZ_HU: misaligned = offset[0];
      SZ_W:        misaligned = (offset != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(logic [2:0] size, logic [1:0] offset);
    case (size)
      SZ_B, SZ_BU: byte_enable = 4'b0001 << offset;
      SZ_H, SZ_HU: byte_enable = 4'b0011 << offset;
      SZ_W:        byte_enable = 4'b1111;
      default:     byte_enable = 4'b0000;
    endcase
  endfunction

  // Replicate so the memory picks the right bytes via byte enables alone.
  function automatic logic [31:0] store_lanes(logic [2:0] size, logic [31:0] data);
    case (size)
      SZ_B, SZ_BU: store_lanes = {4{data[7:0]}};
      SZ_H, SZ_HU: store_lanes = {2{data[15:0]}};
      default:     store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane select and extension of a bus read word.
//   rdata_i  - raw 32-bit word returned by the data memory
//   offset_i - byte offset of the access within the word (addr[1:0])
//   size_i   - funct3 access size (SZ_*)
//   data_o   - selected lane, sign- or zero-extended to 32 bits
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = 32'h0;
    case (size_i)
      SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   data_o = {24'h0, byte_sel};
      SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   data_o = {16'h0, half_sel};
      SZ_W:    data_o = rdata_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32 load or store onto a req/gnt/rvalid data bus.
//   clk, rst              - clock and asynchronous active-high reset
//   MemRead, MemWrite     - current instruction is a load / store (both => store)
//   MemSize               - funct3 access size
//   addr, store_data      - effective byte address and unshifted rs2 value
//   load_data             - aligned, extended load result, valid while done=1
//   stall                 - hold the pipeline while the access is in flight
//   done                  - one-cycle pulse when the access retires
//   lsu_err               - misaligned address or illegal size (no bus traffic)
//   dmem_req/we/addr/be/wdata - bus request fields, stable until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata - bus handshake and read return
module load_store_unit
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemSize,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] load_data_q;
  logic [31:0] aligned_data;

  logic access;
  logic bad_access;
  logic in_idle;
  logic start;

  assign access     = MemRead | MemWrite;
  assign bad_access = !size_legal(MemSize) || misaligned(MemSize, addr[1:0]);
  assign in_idle    = (state_q == StIdle);
  assign start      = in_idle & access & !bad_access;

  // Faults are reported without ever leaving IDLE, so no bus traffic results.
  assign lsu_err = in_idle & access & bad_access;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq:  if (dmem_gnt) state_d = we_q ? StDone : StWait;
      // rvalid is only honoured here, never in the grant cycle.
      StWait: if (dmem_rvalid) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      size_q      <= 3'b000;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= addr;
        size_q  <= MemSize;
        wdata_q <= store_data;
        we_q    <= MemWrite;
      end
      if ((state_q == StWait) && dmem_rvalid) begin
        load_data_q <= aligned_data;
      end
    end
  end

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .data_o   (aligned_data)
  );

  // Stall rises combinationally in the accepting IDLE cycle so the PC freezes at once.
  assign stall      = start | (state_q == StReq) | (state_q == StWait);
  assign done       = (state_q == StDone);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = byte_enable(size_q, addr_q[1:0]);
  assign dmem_wdata = store_lanes(size_q, wdata_q);
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemSize;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        lsu_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks;
  int errors;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemSize     (MemSize),
    .addr        (addr),
    .store_data  (store_data),
    .load_data   (load_data),
    .stall       (stall),
    .done        (done),
    .lsu_err     (lsu_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load with immediate grant and rvalid one cycle later; junk rvalid in the grant cycle.
  task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] a,
                         input logic [3:0] exp_be, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    MemRead = 1'b1; MemSize = size; addr = a; dmem_gnt = 1'b1;
    #1;
    check({tag, "_idle_stall"}, {31'h0, stall}, 32'd1);
    tick();
    MemRead = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check({tag, "_req"}, {31'h0, dmem_req}, 32'd1);
    check({tag, "_we"}, {31'h0, dmem_we}, 32'd0);
    check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, "_be"}, {28'h0, dmem_be}, {28'h0, exp_be});
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    check({tag, "_wait_stall"}, {31'h0, stall}, 32'd1);
    check({tag, "_wait_done"}, {31'h0, done}, 32'd0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #1;
    check({tag, "_done"}, {31'h0, done}, 32'd1);
    check({tag, "_done_stall"}, {31'h0, stall}, 32'd0);
    check({tag, "_data"}, load_data, exp_data);
    tick();
    #1;
    check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    check({tag, "_data_held"}, load_data, exp_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 3'b000; addr = 32'h0;
    store_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'h0, stall}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_req", {31'h0, dmem_req}, 32'd0);
    check("rst_we", {31'h0, dmem_we}, 32'd0);
    check("rst_err", {31'h0, lsu_err}, 32'd0);
    check("rst_load_data", load_data, 32'h0);
    rst = 1'b0;
    tick();

    // SB 0x1003, immediate grant: IDLE -> REQ -> DONE.
    MemWrite = 1'b1; MemSize = 3'b000; addr = 32'h0000_1003; store_data = 32'h0000_00AB;
    dmem_gnt = 1'b1;
    #1;
    check("sb_c1_stall", {31'h0, stall}, 32'd1);
    check("sb_c1_req", {31'h0, dmem_req}, 32'd0);
    tick();
    MemWrite = 1'b0; store_data = 32'h5555_5555;
    #1;
    check("sb_c2_req", {31'h0, dmem_req}, 32'd1);
    check("sb_c2_we", {31'h0, dmem_we}, 32'd1);
    check("sb_c2_addr", dmem_addr, 32'h0000_1000);
    check("sb_c2_be", {28'h0, dmem_be}, 32'h8);
    check("sb_c2_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb_c2_stall", {31'h0, stall}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("sb_c3_done", {31'h0, done}, 32'd1);
    check("sb_c3_stall", {31'h0, stall}, 32'd0);
    check("sb_c3_req", {31'h0, dmem_req}, 32'd0);
    tick();
    #1;
    check("sb_c4_done", {31'h0, done}, 32'd0);

    do_load("lb", 3'b000, 32'h0000_2001, 4'b0010, 32'h1234_80FF, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_2001, 4'b0010, 32'h1234_80FF, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h0000_2002, 4'b1100, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_2002, 4'b1100, 32'h8001_0000, 32'h0000_8001);
    do_load("lw", 3'b010, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load("lb3", 3'b000, 32'h0000_2003, 4'b1000, 32'h7F00_0000, 32'h0000_007F);

    // Misaligned LW and illegal size: error only, no bus traffic, stay idle.
    MemRead = 1'b1; MemSize = 3'b010; addr = 32'h0000_3002;
    #1;
    check("lw_mis_err", {31'h0, lsu_err}, 32'd1);
    check("lw_mis_stall", {31'h0, stall}, 32'd0);
    check("lw_mis_req", {31'h0, dmem_req}, 32'd0);
    tick();
    check("lw_mis_req_next", {31'h0, dmem_req}, 32'd0);
    check("lw_mis_done_next", {31'h0, done}, 32'd0);
    MemSize = 3'b011; addr = 32'h0000_3000;
    #1;
    check("sz011_err", {31'h0, lsu_err}, 32'd1);
    MemRead = 1'b0; MemWrite = 1'b1; MemSize = 3'b001; addr = 32'h0000_3001;
    #1;
    check("sh_mis_err", {31'h0, lsu_err}, 32'd1);
    MemWrite = 1'b0;
    #1;
    check("err_clear", {31'h0, lsu_err}, 32'd0);
    tick();
    check("err_no_req", {31'h0, dmem_req}, 32'd0);

    // SW with grant held off for 5 REQ cycles; request fields must stay put.
    MemWrite = 1'b1; MemSize = 3'b010; addr = 32'h0000_4000; store_data = 32'h1122_3344;
    dmem_gnt = 1'b0;
    tick();
    MemWrite = 1'b0; addr = 32'hFFFF_FFFF; store_data = 32'h0; MemSize = 3'b000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("sw_wait_req", {31'h0, dmem_req}, 32'd1);
      check("sw_wait_addr", dmem_addr, 32'h0000_4000);
      check("sw_wait_be", {28'h0, dmem_be}, 32'hF);
      check("sw_wait_wdata", dmem_wdata, 32'h1122_3344);
      check("sw_wait_stall", {31'h0, stall}, 32'd1);
      check("sw_wait_done", {31'h0, done}, 32'd0);
      tick();
    end
    dmem_gnt = 1'b1;
    #1;
    check("sw_gnt_req", {31'h0, dmem_req}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("sw_done", {31'h0, done}, 32'd1);
    tick();
    check("sw_done_pulse", {31'h0, done}, 32'd0);
    check("sw_idle_stall", {31'h0, stall}, 32'd0);

    // Read+write together is a store: SH with grant goes straight to DONE.
    MemRead = 1'b1; MemWrite = 1'b1; MemSize = 3'b001; addr = 32'h0000_5002;
    store_data = 32'h1234_BEEF; dmem_gnt = 1'b1;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check("rw_we", {31'h0, dmem_we}, 32'd1);
    check("rw_be", {28'h0, dmem_be}, 32'hC);
    check("rw_wdata", dmem_wdata, 32'hBEEF_BEEF);
    tick();
    dmem_gnt = 1'b0;
    check("rw_done", {31'h0, done}, 32'd1);
    tick();

    // Reset while waiting for read data: access abandoned, late rvalid ignored.
    MemRead = 1'b1; MemSize = 3'b010; addr = 32'h0000_6000; dmem_gnt = 1'b1;
    tick();
    MemRead = 1'b0;
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("rst_mid_wait_stall", {31'h0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'h0, stall}, 32'd0);
    check("rst_mid_load_data", load_data, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("rst_mid_done0", {31'h0, done}, 32'd0);
    check("rst_mid_req", {31'h0, dmem_req}, 32'd0);
    tick();
    check("rst_mid_done1", {31'h0, done}, 32'd0);
    check("rst_mid_data", load_data, 32'h0);
    check("rst_mid_idle_stall", {31'h0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
